// File: rtl/imem_loader.sv
// Instruction memory with a valid/ready program loader; serves combinational fetches once loaded.
// Optional IMEM_CHECKSUM_EN: running sum of loaded words, which must total zero at in_last.
module imem_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  reload,
    input  logic [31:0]           raddr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  run,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [31:0]           checksum
);

    // state       | meaning
    // ST_LOAD     | accepting program words, core held
    // ST_RUN      | program loaded, fetches served, core released
    // ST_OVERFLOW | program too long or bad checksum, only reset exits
    // ST_UNUSED   | illegal code, recovers to ST_LOAD
    typedef enum logic [1:0] {
        ST_LOAD     = 2'b00,
        ST_RUN      = 2'b01,
        ST_OVERFLOW = 2'b10,
        ST_UNUSED   = 2'b11
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] WPTR_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] WPTR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    error_q, error_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    accept;
    logic                    at_last_slot;
    logic                    sum_bad;
    logic [31:0]             count_ext;
    logic                    read_hit;

    assign in_ready     = (state_q == ST_LOAD);
    assign accept       = in_valid && in_ready;
    assign at_last_slot = (wptr_q == WPTR_LAST);

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
    logic [31:0] csum_next;

    assign csum_next = csum_q + 32'(in_data);
    assign sum_bad   = (csum_next != 32'd0);
    assign checksum  = csum_q;

    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            csum_d = csum_next;
        end else if (state_q == ST_RUN && reload) begin
            csum_d = 32'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= 32'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`else
    assign sum_bad  = 1'b0;
    assign checksum = 32'd0;
`endif

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        error_d = error_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    wptr_d  = wptr_q + WPTR_ONE;
                    count_d = count_q + CNT_ONE;
                    if (in_last) begin
                        if (sum_bad) begin
                            state_d = ST_OVERFLOW;
                            error_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (at_last_slot) begin
                        state_d = ST_OVERFLOW;
                        error_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Old memory contents remain but are hidden behind word_count.
                if (reload) begin
                    state_d = ST_LOAD;
                    wptr_d  = '0;
                    count_d = '0;
                end
            end
            ST_OVERFLOW: begin
                state_d = ST_OVERFLOW;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LOAD;
            wptr_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    // Full 32-bit compare so high raddr bits can never alias into the array.
    assign count_ext = {{(32 - ADDR_WIDTH - 1){1'b0}}, count_q};
    assign read_hit  = (state_q == ST_RUN) && (raddr < count_ext);
    assign instr     = read_hit ? mem_q[raddr[ADDR_WIDTH-1:0]] : '0;

    assign run        = (state_q == ST_RUN);
    assign error      = error_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized bench for imem_loader against a behavioural program-memory model.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        reload;
    logic [31:0] raddr;
    logic [31:0] instr;
    logic        run;
    logic        error;
    logic [6:0]  word_count;
    logic [31:0] checksum;

    imem_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .reload     (reload),
        .raddr      (raddr),
        .instr      (instr),
        .run        (run),
        .error      (error),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = loading, 1 = running, 2 = overflowed
    logic [31:0] m_mem [64];
    int          m_count;
    int          m_mode;
    bit          m_err;
    logic [31:0] m_sum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_csum();
`ifdef IMEM_CHECKSUM_EN
        return m_sum;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        if (m_mode == 1 && a < 32'(m_count)) return m_mem[a[5:0]];
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_mode  = 0;
        m_err   = 1'b0;
        m_sum   = 32'd0;
    endtask

    task automatic check_status(input string tag, input bit with_ready);
        chk({tag, ".run"}, 64'(run), 64'(m_mode == 1));
        chk({tag, ".error"}, 64'(error), 64'(m_err));
        chk({tag, ".word_count"}, 64'(word_count), 64'(m_count));
        chk({tag, ".checksum"}, 64'(checksum), 64'(exp_csum()));
        if (with_ready) chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_mode == 0));
    endtask

    task automatic read_check(input string tag, input logic [31:0] a);
        raddr = a;
        #1;
        chk(tag, 64'(instr), 64'(exp_instr(a)));
    endtask

    // One clock with the given inputs, then advance the model by the spec rules.
    task automatic step(input bit v, input logic [31:0] d, input bit last, input bit rld);
        in_valid = v;
        in_data  = d;
        in_last  = last;
        reload   = rld;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        reload   = 1'b0;
        if (v && m_mode == 0) begin
            m_mem[m_count] = d;
            m_count++;
            m_sum = m_sum + d;
            if (last) begin
`ifdef IMEM_CHECKSUM_EN
                if (m_sum != 32'd0) begin m_mode = 2; m_err = 1'b1; end
                else m_mode = 1;
`else
                m_mode = 1;
`endif
            end else if (m_count == 64) begin
                m_mode = 2;
                m_err  = 1'b1;
            end
        end else if (rld && m_mode == 1) begin
            m_mode  = 0;
            m_count = 0;
            m_sum   = 32'd0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #3;
        check_status("in_reset", 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_status("after_reset", 1'b1);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] s;
        int          n;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        in_last  = 1'b0;
        reload   = 1'b0;
        raddr    = 32'd0;
        model_reset();
        #12;
        check_status("por", 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_status("por_release", 1'b1);
        read_check("load_instr_zero", 32'd0);

        step(1'b1, 32'h2001_0005, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0000, 1'b0, 1'b0);
        check_status("three_mid", 1'b1);
        step(1'b1, 32'h0000_000D, 1'b1, 1'b0);
        check_status("three_done", 1'b1);
        for (int a = 0; a < 4; a++) read_check("three_read", 32'(a));
        read_check("three_read_hi", 32'h40);

        step(1'b0, 32'd0, 1'b0, 1'b1);
        check_status("reload", 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check_status("reload_in_load", 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1'b1, $urandom, 1'b0, 1'b0);
            else            step(1'b0, $urandom, 1'b1, 1'b0);
        end
        check_status("toggle_load", 1'b1);
        step(1'b1, $urandom, 1'b1, 1'b0);
        check_status("toggle_done", 1'b1);
        for (int i = 0; i < 10; i++) read_check("toggle_read", 32'($urandom_range(0, 15)));

        step(1'b1, 32'h1234_5678, 1'b1, 1'b1);
        check_status("reload_with_valid", 1'b1);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check_status("deadbeef", 1'b1);
        read_check("deadbeef_r0", 32'd0);
        read_check("stale_r1", 32'd1);
        read_check("stale_r2", 32'd2);
        read_check("hi_0x40", 32'h40);
        read_check("hi_msb", 32'h8000_0000);

        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        check_status("overflow", 1'b1);
        read_check("overflow_read", 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check_status("overflow_reload", 1'b1);
        step(1'b1, $urandom, 1'b1, 1'b0);
        check_status("overflow_valid", 1'b1);
        do_reset();

        s = 32'd0;
        for (int i = 0; i < 63; i++) begin
            w = $urandom;
            s = s + w;
            step(1'b1, w, 1'b0, 1'b0);
        end
`ifdef IMEM_CHECKSUM_EN
        step(1'b1, -s, 1'b1, 1'b0);
`else
        step(1'b1, $urandom, 1'b1, 1'b0);
`endif
        check_status("exact_fit", 1'b1);
        read_check("exact_r63", 32'd63);
        read_check("exact_r64", 32'd64);
        for (int i = 0; i < 8; i++) read_check("exact_rand", 32'($urandom_range(0, 70)));

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_status("midcycle_reset", 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("midcycle_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        check_status("midcycle_release", 1'b1);

        for (int p = 0; p < 3; p++) begin
            do_reset();
            n = $urandom_range(1, 20);
            s = 32'd0;
            for (int i = 0; i < n - 1; i++) begin
                w = $urandom;
                s = s + w;
                step(($urandom_range(0, 3) != 0), w, 1'b0, 1'b0);
                if (!(m_count > i)) s = s - w;
            end
`ifdef IMEM_CHECKSUM_EN
            step(1'b1, -s, 1'b1, 1'b0);
`else
            step(1'b1, $urandom, 1'b1, 1'b0);
`endif
            check_status("rand_prog", 1'b1);
            for (int i = 0; i < 12; i++) read_check("rand_read", 32'($urandom_range(0, 24)));
        end

`ifdef IMEM_CHECKSUM_EN
        do_reset();
        step(1'b1, 32'd5, 1'b0, 1'b0);
        step(1'b1, 32'd7, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFF4, 1'b1, 1'b0);
        check_status("csum_good", 1'b1);
        chk("csum_good_run", 64'(run), 64'd1);
        do_reset();
        step(1'b1, 32'd5, 1'b0, 1'b0);
        step(1'b1, 32'd7, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFF5, 1'b1, 1'b0);
        check_status("csum_bad", 1'b1);
        chk("csum_bad_error", 64'(error), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
